// File: rtl/lcd_pkg.sv
// Shared definitions for the ST7789-class bring-up/fill sequencer:
// one-hot state encoding, DCS command bytes, MADCTL-by-rotation table and colours.
package lcd_pkg;

    typedef enum logic [7:0] {
        ST_RST_LOW  = 8'b0000_0001,
        ST_RST_HIGH = 8'b0000_0010,
        ST_SLPOUT   = 8'b0000_0100,
        ST_SLP_WAIT = 8'b0000_1000,
        ST_INIT     = 8'b0001_0000,
        ST_WIN      = 8'b0010_0000,
        ST_PIX      = 8'b0100_0000,
        ST_READY    = 8'b1000_0000
    } state_t;

    localparam int CNT_W   = 23;
    localparam int HDR_LEN = 13;

    localparam logic [7:0] CMD_SLPOUT = 8'h11;
    localparam logic [7:0] CMD_MADCTL = 8'h36;
    localparam logic [7:0] CMD_CASET  = 8'h2A;
    localparam logic [7:0] CMD_RASET  = 8'h2B;
    localparam logic [7:0] CMD_RAMWR  = 8'h2C;

    // Memory-access control values giving 0/90/180/270 degree scan orders
    localparam logic [7:0] MADCTL_BY_ROT [4] = '{8'h00, 8'h60, 8'hC0, 8'hA0};

    localparam logic [15:0] COLOR_BLACK = 16'h0000;

endpackage

// File: rtl/lcd_init_rom.sv
// Panel register table sent after SLPOUT; bit 8 marks a data byte, 0 a command byte.
module lcd_init_rom
    import lcd_pkg::*;
(
    input  logic [6:0] addr,
    output logic [8:0] data
);

    always_comb begin
        data = 9'h000;
        case (addr)
            7'd0:  data = 9'h03A;  7'd1:  data = 9'h155;
            7'd2:  data = 9'h0B2;  7'd3:  data = 9'h10C;  7'd4:  data = 9'h10C;
            7'd5:  data = 9'h100;  7'd6:  data = 9'h133;  7'd7:  data = 9'h133;
            7'd8:  data = 9'h0BB;  7'd9:  data = 9'h119;
            7'd10: data = 9'h0C0;  7'd11: data = 9'h12C;
            7'd12: data = 9'h0C2;  7'd13: data = 9'h101;
            7'd14: data = 9'h0C3;  7'd15: data = 9'h112;
            7'd16: data = 9'h0C4;  7'd17: data = 9'h120;
            7'd18: data = 9'h0C6;  7'd19: data = 9'h10F;
            7'd20: data = 9'h0D0;  7'd21: data = 9'h1A4;  7'd22: data = 9'h1A1;
            // Positive gamma curve
            7'd23: data = 9'h0E0;  7'd24: data = 9'h1D0;  7'd25: data = 9'h104;
            7'd26: data = 9'h10D;  7'd27: data = 9'h111;  7'd28: data = 9'h113;
            7'd29: data = 9'h12B;  7'd30: data = 9'h13F;  7'd31: data = 9'h154;
            7'd32: data = 9'h14C;  7'd33: data = 9'h118;  7'd34: data = 9'h10D;
            7'd35: data = 9'h10B;  7'd36: data = 9'h11F;  7'd37: data = 9'h123;
            // Negative gamma curve
            7'd38: data = 9'h0E1;  7'd39: data = 9'h1D0;  7'd40: data = 9'h104;
            7'd41: data = 9'h10C;  7'd42: data = 9'h111;  7'd43: data = 9'h113;
            7'd44: data = 9'h12C;  7'd45: data = 9'h13F;  7'd46: data = 9'h144;
            7'd47: data = 9'h151;  7'd48: data = 9'h12F;  7'd49: data = 9'h11F;
            7'd50: data = 9'h11F;  7'd51: data = 9'h120;  7'd52: data = 9'h123;
            7'd53: data = 9'h021;  7'd54: data = 9'h013;  7'd55: data = 9'h029;
            default: data = 9'h000;
        endcase
    end

endmodule

// File: rtl/lcd_init_fill_ctrl.sv
// Power-on sequencer, full-screen clear and rectangle filler for an ST7789-class panel.
// Presents one {dc,byte} word at a time to the SPI writer and advances on its wr_done pulse.
module lcd_init_fill_ctrl
    import lcd_pkg::*;
#(
    parameter int H_RES      = 240,
    parameter int V_RES      = 320,
    parameter int T_RST_LOW  = 5_000_000,
    parameter int T_RST_HIGH = 2_500_000,
    parameter int T_SLPOUT   = 6_000_000,
    parameter int ROM_LEN    = 56,
    parameter int PIX_W      = $clog2(H_RES*V_RES*2+1)
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst,
    input  logic        wr_done,
    input  logic        fill_req,
    input  logic [15:0] fill_color,
    input  logic [8:0]  win_x0,
    input  logic [8:0]  win_x1,
    input  logic [8:0]  win_y0,
    input  logic [8:0]  win_y1,
    input  logic [1:0]  rot,
    output logic        lcd_rst,
    output logic [8:0]  init_data,
    output logic        en_write,
    output logic        init_done,
    output logic        busy,
    output logic        fill_done,
    output logic        fill_err
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         idx_q, idx_d;
    logic [PIX_W-1:0]   pix_q, pix_d, total_q, total_d;
    logic [15:0]        color_q, color_d;
    logic [1:0]         rot_q, rot_d;
    logic [8:0]         x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic               lcd_rst_q, lcd_rst_d, en_write_q, en_write_d;
    logic               init_done_q, init_done_d, busy_q, busy_d;
    logic               fill_done_q, fill_done_d, fill_err_q, fill_err_d;
    logic [8:0]         init_data_q, init_data_d;

    logic [8:0]         w_max, h_max, x1_clamp, y1_clamp, hdr_byte, rom_data;
    logic [PIX_W-1:0]   req_w, req_h, req_bytes;
    logic               req_bad;

    lcd_init_rom u_rom (
        .addr (idx_d),
        .data (rom_data)
    );

    // A quarter-turn swaps the visible frame's width and height
    always_comb begin
        w_max     = rot[0] ? 9'(V_RES - 1) : 9'(H_RES - 1);
        h_max     = rot[0] ? 9'(H_RES - 1) : 9'(V_RES - 1);
        x1_clamp  = (win_x1 > w_max) ? w_max : win_x1;
        y1_clamp  = (win_y1 > h_max) ? h_max : win_y1;
        req_bad   = (win_x0 > x1_clamp) || (win_y0 > y1_clamp) || (win_x0 > w_max) || (win_y0 > h_max);
        req_w     = PIX_W'(x1_clamp - win_x0) + PIX_W'(1);
        req_h     = PIX_W'(y1_clamp - win_y0) + PIX_W'(1);
        req_bytes = (req_w * req_h) << 1;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pix_d      = pix_q;
        total_d    = total_q;
        color_d    = color_q;
        rot_d      = rot_q;
        x0_d       = x0_q;
        x1_d       = x1_q;
        y0_d       = y0_q;
        y1_d       = y1_q;
        fill_err_d = 1'b0;
        unique case (state_q)
            ST_RST_LOW: begin
                if (cnt_q == '0) begin
                    state_d = ST_RST_HIGH;
                    cnt_d   = CNT_W'(T_RST_HIGH - 1);
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            ST_RST_HIGH: begin
                if (cnt_q == '0) state_d = ST_SLPOUT;
                else cnt_d = cnt_q - CNT_W'(1);
            end
            ST_SLPOUT: begin
                if (wr_done) begin
                    state_d = ST_SLP_WAIT;
                    cnt_d   = CNT_W'(T_SLPOUT - 1);
                end
            end
            ST_SLP_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_INIT;
                    idx_d   = '0;
                end else cnt_d = cnt_q - CNT_W'(1);
            end
            ST_INIT: begin
                // The register table is followed by a black full-screen clear
                if (wr_done && idx_q == 7'(ROM_LEN - 1)) begin
                    state_d = ST_WIN;
                    idx_d   = '0;
                    color_d = COLOR_BLACK;
                    rot_d   = 2'd0;
                    x0_d    = '0;
                    x1_d    = 9'(H_RES - 1);
                    y0_d    = '0;
                    y1_d    = 9'(V_RES - 1);
                    total_d = PIX_W'(H_RES * V_RES * 2);
                end else if (wr_done) idx_d = idx_q + 7'd1;
            end
            ST_WIN: begin
                if (wr_done && idx_q == 7'(HDR_LEN - 1)) begin
                    state_d = ST_PIX;
                    pix_d   = '0;
                end else if (wr_done) idx_d = idx_q + 7'd1;
            end
            ST_PIX: begin
                if (wr_done && pix_q == total_q - PIX_W'(1)) state_d = ST_READY;
                else if (wr_done) pix_d = pix_q + PIX_W'(1);
            end
            ST_READY: begin
                if (fill_req && req_bad) fill_err_d = 1'b1;
                else if (fill_req) begin
                    state_d = ST_WIN;
                    idx_d   = '0;
                    color_d = fill_color;
                    rot_d   = rot;
                    x0_d    = win_x0;
                    x1_d    = x1_clamp;
                    y0_d    = win_y0;
                    y1_d    = y1_clamp;
                    total_d = req_bytes;
                end
            end
            default: begin
                state_d = ST_RST_LOW;
                cnt_d   = CNT_W'(T_RST_LOW - 1);
            end
        endcase
    end

    // Outputs are derived from the next state so they change on the same edge as the state
    always_comb begin
        hdr_byte = 9'h000;
        case (idx_d)
            7'd0:  hdr_byte = {1'b0, CMD_MADCTL};
            7'd1:  hdr_byte = {1'b1, MADCTL_BY_ROT[rot_d]};
            7'd2:  hdr_byte = {1'b0, CMD_CASET};
            7'd3:  hdr_byte = {1'b1, 7'b0, x0_d[8]};
            7'd4:  hdr_byte = {1'b1, x0_d[7:0]};
            7'd5:  hdr_byte = {1'b1, 7'b0, x1_d[8]};
            7'd6:  hdr_byte = {1'b1, x1_d[7:0]};
            7'd7:  hdr_byte = {1'b0, CMD_RASET};
            7'd8:  hdr_byte = {1'b1, 7'b0, y0_d[8]};
            7'd9:  hdr_byte = {1'b1, y0_d[7:0]};
            7'd10: hdr_byte = {1'b1, 7'b0, y1_d[8]};
            7'd11: hdr_byte = {1'b1, y1_d[7:0]};
            7'd12: hdr_byte = {1'b0, CMD_RAMWR};
            default: hdr_byte = 9'h000;
        endcase
        init_data_d = 9'h000;
        case (state_d)
            ST_SLPOUT: init_data_d = {1'b0, CMD_SLPOUT};
            ST_INIT:   init_data_d = rom_data;
            ST_WIN:    init_data_d = hdr_byte;
            ST_PIX:    init_data_d = pix_d[0] ? {1'b1, color_d[7:0]} : {1'b1, color_d[15:8]};
            default:   init_data_d = 9'h000;
        endcase
        lcd_rst_d   = (state_d != ST_RST_LOW);
        en_write_d  = (state_d == ST_SLPOUT) || (state_d == ST_INIT) ||
                      (state_d == ST_WIN) || (state_d == ST_PIX);
        busy_d      = (state_d != ST_READY);
        init_done_d = init_done_q || (state_d == ST_READY);
        fill_done_d = (state_q != ST_READY) && (state_d == ST_READY);
    end

    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            state_q     <= ST_RST_LOW;
            cnt_q       <= CNT_W'(T_RST_LOW - 1);
            idx_q       <= '0;
            pix_q       <= '0;
            total_q     <= '0;
            color_q     <= '0;
            rot_q       <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            y0_q        <= '0;
            y1_q        <= '0;
            lcd_rst_q   <= 1'b0;
            init_data_q <= 9'h000;
            en_write_q  <= 1'b0;
            init_done_q <= 1'b0;
            busy_q      <= 1'b1;
            fill_done_q <= 1'b0;
            fill_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pix_q       <= pix_d;
            total_q     <= total_d;
            color_q     <= color_d;
            rot_q       <= rot_d;
            x0_q        <= x0_d;
            x1_q        <= x1_d;
            y0_q        <= y0_d;
            y1_q        <= y1_d;
            lcd_rst_q   <= lcd_rst_d;
            init_data_q <= init_data_d;
            en_write_q  <= en_write_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            fill_done_q <= fill_done_d;
            fill_err_q  <= fill_err_d;
        end
    end

    assign lcd_rst   = lcd_rst_q;
    assign init_data = init_data_q;
    assign en_write  = en_write_q;
    assign init_done = init_done_q;
    assign busy      = busy_q;
    assign fill_done = fill_done_q;
    assign fill_err  = fill_err_q;

endmodule

// File: tb/tb_lcd_init_fill_ctrl.sv
// Directed bench for lcd_init_fill_ctrl on a reduced 24x32 panel with short reset/sleep delays.
// A writer model answers each byte with wr_done three cycles after it appears.
module tb_lcd_init_fill_ctrl;

    localparam int H_RES       = 24;
    localparam int V_RES       = 32;
    localparam int T_RST_LOW   = 10;
    localparam int T_RST_HIGH  = 5;
    localparam int T_SLPOUT    = 8;
    localparam int ROM_LEN     = 56;
    localparam int CLEAR_BYTES = H_RES * V_RES * 2;

    localparam logic [8:0] ROM_EXP [56] = '{
        9'h03A, 9'h155, 9'h0B2, 9'h10C, 9'h10C, 9'h100, 9'h133, 9'h133,
        9'h0BB, 9'h119, 9'h0C0, 9'h12C, 9'h0C2, 9'h101, 9'h0C3, 9'h112,
        9'h0C4, 9'h120, 9'h0C6, 9'h10F, 9'h0D0, 9'h1A4, 9'h1A1,
        9'h0E0, 9'h1D0, 9'h104, 9'h10D, 9'h111, 9'h113, 9'h12B, 9'h13F,
        9'h154, 9'h14C, 9'h118, 9'h10D, 9'h10B, 9'h11F, 9'h123,
        9'h0E1, 9'h1D0, 9'h104, 9'h10C, 9'h111, 9'h113, 9'h12C, 9'h13F,
        9'h144, 9'h151, 9'h12F, 9'h11F, 9'h11F, 9'h120, 9'h123,
        9'h021, 9'h013, 9'h029
    };

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        wr_done = 1'b0;
    logic        fill_req = 1'b0;
    logic [15:0] fill_color = '0;
    logic [8:0]  win_x0 = '0, win_x1 = '0, win_y0 = '0, win_y1 = '0;
    logic [1:0]  rot = '0;
    logic        lcd_rst, en_write, init_done, busy, fill_done, fill_err;
    logic [8:0]  init_data;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  sent  [$];
    logic [8:0]  exp_q [$];
    int          fill_done_cnt = 0;
    int          fill_err_cnt = 0;
    int          wcnt = 0;

    always #5 clk = ~clk;

    lcd_init_fill_ctrl #(
        .H_RES      (H_RES),
        .V_RES      (V_RES),
        .T_RST_LOW  (T_RST_LOW),
        .T_RST_HIGH (T_RST_HIGH),
        .T_SLPOUT   (T_SLPOUT),
        .ROM_LEN    (ROM_LEN)
    ) dut (
        .sys_clk_50MHz (clk),
        .sys_rst       (sys_rst),
        .wr_done       (wr_done),
        .fill_req      (fill_req),
        .fill_color    (fill_color),
        .win_x0        (win_x0),
        .win_x1        (win_x1),
        .win_y0        (win_y0),
        .win_y1        (win_y1),
        .rot           (rot),
        .lcd_rst       (lcd_rst),
        .init_data     (init_data),
        .en_write      (en_write),
        .init_done     (init_done),
        .busy          (busy),
        .fill_done     (fill_done),
        .fill_err      (fill_err)
    );

    // Byte writer: pulses wr_done on the third edge after a byte is presented
    always @(posedge clk) begin
        wr_done <= 1'b0;
        if (sys_rst) wcnt <= 0;
        else if (en_write && !wr_done) begin
            if (wcnt == 2) begin
                wr_done <= 1'b1;
                wcnt    <= 0;
            end else wcnt <= wcnt + 1;
        end else wcnt <= 0;
    end

    // Records every completed byte and counts status pulses
    always @(negedge clk) begin
        if (en_write && wr_done) sent.push_back(init_data);
        if (fill_done) fill_done_cnt <= fill_done_cnt + 1;
        if (fill_err)  fill_err_cnt  <= fill_err_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] r, input logic [8:0] x0, input logic [8:0] x1,
                                 input logic [8:0] y0, input logic [8:0] y1, input logic [15:0] c);
        @(posedge clk); #1;
        rot = r; win_x0 = x0; win_x1 = x1; win_y0 = y0; win_y1 = y1; fill_color = c;
        fill_req = 1'b1;
        @(posedge clk); #1;
        fill_req = 1'b0;
    endtask

    task automatic waitFillDone(input string tag, input int budget);
        int base = fill_done_cnt;
        int n = 0;
        while (fill_done_cnt == base && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " fill_done seen"}, 32'(fill_done_cnt != base), 1);
    endtask

    task automatic waitBytes(input string tag, input int total, input int budget);
        int n = 0;
        while (sent.size() < total && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({tag, " bytes reached"}, 32'(sent.size() >= total), 1);
    endtask

    task automatic pushHeader(input logic [7:0] madctl, input logic [8:0] x0, input logic [8:0] x1,
                              input logic [8:0] y0, input logic [8:0] y1);
        exp_q.push_back(9'h036);
        exp_q.push_back({1'b1, madctl});
        exp_q.push_back(9'h02A);
        exp_q.push_back({1'b1, 7'b0, x0[8]});
        exp_q.push_back({1'b1, x0[7:0]});
        exp_q.push_back({1'b1, 7'b0, x1[8]});
        exp_q.push_back({1'b1, x1[7:0]});
        exp_q.push_back(9'h02B);
        exp_q.push_back({1'b1, 7'b0, y0[8]});
        exp_q.push_back({1'b1, y0[7:0]});
        exp_q.push_back({1'b1, 7'b0, y1[8]});
        exp_q.push_back({1'b1, y1[7:0]});
        exp_q.push_back(9'h02C);
    endtask

    task automatic pushPixels(input logic [15:0] c, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back((i % 2 == 0) ? {1'b1, c[15:8]} : {1'b1, c[7:0]});
    endtask

    task automatic buildPowerUp();
        exp_q.delete();
        exp_q.push_back(9'h011);
        for (int i = 0; i < ROM_LEN; i++) exp_q.push_back(ROM_EXP[i]);
        pushHeader(8'h00, 9'd0, 9'd23, 9'd0, 9'd31);
        pushPixels(16'h0000, CLEAR_BYTES);
    endtask

    task automatic compareBytes(input string tag, input int base);
        int bad = 0;
        int first = -1;
        checkOutput({tag, " byte count"}, 32'(sent.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i >= sent.size() || sent[base + i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (first >= 0) $display("[TB] %s first differing byte at index %0d", tag, first);
        checkOutput({tag, " byte values"}, 32'(bad), 0);
    endtask

    initial begin
        int base;
        int done0;
        int err0;

        // Reset state
        sys_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset lcd_rst", 32'(lcd_rst), 0);
        checkOutput("reset init_data", 32'(init_data), 0);
        checkOutput("reset en_write", 32'(en_write), 0);
        checkOutput("reset init_done", 32'(init_done), 0);
        checkOutput("reset busy", 32'(busy), 1);
        checkOutput("reset fill_done", 32'(fill_done), 0);
        checkOutput("reset fill_err", 32'(fill_err), 0);

        // Power-up: lcd_rst rises on the 10th edge after release, then SLPOUT, ROM, clear
        base = sent.size();
        sys_rst = 1'b0;
        repeat (T_RST_LOW - 1) @(posedge clk);
        #1;
        checkOutput("lcd_rst before cycle 10", 32'(lcd_rst), 0);
        @(posedge clk); #1;
        checkOutput("lcd_rst at cycle 10", 32'(lcd_rst), 1);
        checkOutput("en_write in reset wait", 32'(en_write), 0);
        checkOutput("init_done during power-up", 32'(init_done), 0);
        waitFillDone("power-up", 20000);
        buildPowerUp();
        compareBytes("power-up", base);
        checkOutput("power-up init_done", 32'(init_done), 1);
        checkOutput("power-up busy", 32'(busy), 0);
        checkOutput("power-up fill_done count", 32'(fill_done_cnt), 1);

        // Rotated fill, 2x2 window of red
        base = sent.size();
        applyStimulus(2'd3, 9'd10, 9'd11, 9'd20, 9'd21, 16'hF800);
        checkOutput("rot3 busy after accept", 32'(busy), 1);
        waitFillDone("rot3", 2000);
        exp_q = '{9'h036, 9'h1A0, 9'h02A, 9'h100, 9'h10A, 9'h100, 9'h10B,
                  9'h02B, 9'h100, 9'h114, 9'h100, 9'h115, 9'h02C};
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(9'h1F8);
            exp_q.push_back(9'h100);
        end
        compareBytes("rot3", base);
        checkOutput("rot3 init_done", 32'(init_done), 1);

        // Clamp: x1 and y1 beyond the frame are pulled to 23 and 31
        base = sent.size();
        applyStimulus(2'd0, 9'd20, 9'd400, 9'd30, 9'd400, 16'h07E0);
        waitFillDone("clamp", 2000);
        exp_q.delete();
        pushHeader(8'h00, 9'd20, 9'd23, 9'd30, 9'd31);
        pushPixels(16'h07E0, 16);
        compareBytes("clamp", base);

        // Corner pixel in the 90-degree frame (32 wide, 24 high) is accepted
        base = sent.size();
        applyStimulus(2'd1, 9'd31, 9'd31, 9'd23, 9'd23, 16'h001F);
        waitFillDone("rot1 corner", 2000);
        exp_q.delete();
        pushHeader(8'h60, 9'd31, 9'd31, 9'd23, 9'd23);
        pushPixels(16'h001F, 2);
        compareBytes("rot1 corner", base);

        // Rejections: inverted x, x0 past width, y0 past height in rotated frame
        base = sent.size();
        err0 = fill_err_cnt;
        applyStimulus(2'd0, 9'd5, 9'd3, 9'd0, 9'd0, 16'hFFFF);
        checkOutput("reject x0>x1 fill_err", 32'(fill_err), 1);
        checkOutput("reject x0>x1 busy", 32'(busy), 0);
        checkOutput("reject x0>x1 en_write", 32'(en_write), 0);
        @(posedge clk); #1;
        checkOutput("reject fill_err one cycle", 32'(fill_err), 0);
        applyStimulus(2'd0, 9'd24, 9'd30, 9'd0, 9'd0, 16'hFFFF);
        checkOutput("reject x0>=W fill_err", 32'(fill_err), 1);
        applyStimulus(2'd1, 9'd0, 9'd0, 9'd24, 9'd24, 16'hFFFF);
        checkOutput("reject rot1 y0>=H fill_err", 32'(fill_err), 1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("reject en_write idle", 32'(en_write), 0);
        checkOutput("reject busy idle", 32'(busy), 0);
        checkOutput("reject nothing sent", 32'(sent.size() - base), 0);
        checkOutput("reject fill_err count", 32'(fill_err_cnt - err0), 3);

        // Request during PIX is dropped
        base = sent.size();
        done0 = fill_done_cnt;
        err0 = fill_err_cnt;
        applyStimulus(2'd2, 9'd0, 9'd3, 9'd0, 9'd1, 16'h1234);
        waitBytes("busy req", base + 15, 500);
        applyStimulus(2'd0, 9'd0, 9'd0, 9'd0, 9'd0, 16'hFFFF);
        checkOutput("busy req still busy", 32'(busy), 1);
        checkOutput("busy req no fill_err", 32'(fill_err), 0);
        waitFillDone("busy req", 2000);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("busy req one fill_done", 32'(fill_done_cnt - done0), 1);
        checkOutput("busy req no error pulse", 32'(fill_err_cnt - err0), 0);
        exp_q.delete();
        pushHeader(8'hC0, 9'd0, 9'd3, 9'd0, 9'd1);
        pushPixels(16'h1234, 16);
        compareBytes("busy req", base);

        // Reset during PIX restarts the full power-up
        base = sent.size();
        applyStimulus(2'd0, 9'd0, 9'd23, 9'd0, 9'd31, 16'hFFFF);
        waitBytes("mid-fill", base + 20, 500);
        @(posedge clk); #1;
        sys_rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("mid-fill reset lcd_rst", 32'(lcd_rst), 0);
        checkOutput("mid-fill reset en_write", 32'(en_write), 0);
        checkOutput("mid-fill reset init_done", 32'(init_done), 0);
        checkOutput("mid-fill reset busy", 32'(busy), 1);
        sys_rst = 1'b0;
        base = sent.size();
        waitFillDone("re-power-up", 20000);
        buildPowerUp();
        compareBytes("re-power-up", base);
        checkOutput("re-power-up init_done", 32'(init_done), 1);
        checkOutput("re-power-up lcd_rst", 32'(lcd_rst), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
